// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES key expansion, one schedule word per clock
// Holds the full round-key schedule stable in DONE until the next load.
module aes_key_expand_seq #(
   parameter int Nk = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [32*Nk-1:0]  key,
   output logic [127:0]      k_sch [0:Nk+6],
   output logic              valid,
   output logic              busy
);

   localparam int Nr = Nk + 6;
   localparam int NW = 4 * (Nr + 1);
   localparam logic [5:0] NK6     = 6'(Nk);
   localparam logic [5:0] LAST    = 6'(NW - 1);
   localparam logic [2:0] MODLAST = 3'(Nk - 1);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t      state, next_state;
   logic [31:0] w [0:NW-1];
   logic [5:0]  idx;
   logic [2:0]  mod_cnt;
   logic [7:0]  rcon;
   logic [31:0] temp;
   logic [5:0]  prev, back;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse as x^254, then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv, base;
      inv  = 8'h01;
      base = x;
      for (int i = 1; i < 8; i++) begin
         base = gf_mul(base, base);
         inv  = gf_mul(inv, base);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   assign prev = idx - 6'd1;
   assign back = idx - NK6;

   always_comb begin
      temp = w[prev];
      if (mod_cnt == 3'd0)
         temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
      else if (Nk == 8 && mod_cnt == 3'd4)
         temp = sub_word(temp);
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (load) next_state = EXPAND;
         EXPAND: begin
            if (load)              next_state = EXPAND;
            else if (idx == LAST)  next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         valid <= (next_state == DONE);
         busy  <= (next_state == EXPAND);
      end
   end

   // load wins over an in-flight expansion, restarting from the new key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) w[i] <= '0;
         idx     <= 6'd0;
         mod_cnt <= 3'd0;
         rcon    <= 8'h01;
      end else if (load) begin
         for (int i = 0; i < Nk; i++) w[i] <= key[32*(Nk-i)-1 -: 32];
         idx     <= NK6;
         mod_cnt <= 3'd0;
         rcon    <= 8'h01;
      end else if (state == EXPAND) begin
         w[idx]  <= w[back] ^ temp;
         idx     <= idx + 6'd1;
         mod_cnt <= (mod_cnt == MODLAST) ? 3'd0 : mod_cnt + 3'd1;
         if (mod_cnt == 3'd0) rcon <= xtime(rcon);
      end
   end

   always_comb begin
      for (int r = 0; r <= Nr; r++)
         k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   end

endmodule
